mostrador7_leitor: RTL and testbench

MOSTRADOR7_LEITOR -- requirements
Module: mostrador7_leitor

---
 rtl/mostrador7_leitor_pkg.sv | 43 ++++
 rtl/mostrador7_leitor_if.sv | 34 +++
 rtl/mostrador7_leitor_seg7_padrao_dec.sv | 26 ++
 rtl/mostrador7_leitor.sv | 163 ++++++++++++++++
 tb/tb_mostrador7_leitor.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/mostrador7_leitor_pkg.sv
// Shared definitions for the seven-segment status reader: segment patterns,
// status code encoding and filter FSM states.
package mostrador7_leitor_pkg;

    // Segment patterns as driven by the display encoder (bit0 = A .. bit6 = G)
    localparam logic [6:0] PAT_NENHUM  = 7'h7F;
    localparam logic [6:0] PAT_CRITICO = 7'h27;
    localparam logic [6:0] PAT_BAIXO   = 7'h77;
    localparam logic [6:0] PAT_MEDIO   = 7'h37;
    localparam logic [6:0] PAT_ALTO    = 7'h36;
    localparam logic [6:0] PAT_ERR     = 7'h06;
    localparam logic [6:0] PAT_BS      = 7'h03;
    localparam logic [6:0] PAT_VS      = 7'h63;

    typedef enum logic [2:0] {
        ST_NENHUM  = 3'd0,
        ST_CRITICO = 3'd1,
        ST_BAIXO   = 3'd2,
        ST_MEDIO   = 3'd3,
        ST_ALTO    = 3'd4,
        ST_ERR     = 3'd5,
        ST_BS      = 3'd6,
        ST_VS      = 3'd7
    } status_t;

    typedef enum logic [1:0] {
        ESPERA  = 2'd0,
        FILTRA  = 2'd1,
        ESTAVEL = 2'd2
    } estado_t;

    // One-hot view: bits 0..7 follow the status code, bit 8 is the invalid flag
    function automatic logic [8:0] status_onehot(status_t codigo, logic invalido);
        logic [8:0] oh;
        if (invalido) begin
            oh = 9'h100;
        end else begin
            oh = 9'(9'd1 << codigo);
        end
        return oh;
    endfunction

endpackage

// File: rtl/mostrador7_leitor_if.sv
// Display-side pins and decoded indications of the seven-segment status reader.
interface mostrador7_leitor_if;
    logic [6:0] SEGs;
    logic       SEG_D1;
    logic       SEG_D2;
    logic       SEG_D3;
    logic       SEG_D4;

    logic       Nv_Critico;
    logic       Nv_Baixo;
    logic       Nv_Medio;
    logic       Nv_Alto;
    logic       Err;
    logic       Bs;
    logic       Vs;
    logic       Sd;
    logic       Nenhum;
    logic       Invalido;
    logic       Sem_Sinal;
    logic       Atualiza;

    modport master (
        output SEGs, SEG_D1, SEG_D2, SEG_D3, SEG_D4,
        input  Nv_Critico, Nv_Baixo, Nv_Medio, Nv_Alto, Err, Bs, Vs, Sd,
               Nenhum, Invalido, Sem_Sinal, Atualiza
    );

    // The reader only looks at digit 1; the other enables stay on the bus side
    modport slave (
        input  SEGs, SEG_D1,
        output Nv_Critico, Nv_Baixo, Nv_Medio, Nv_Alto, Err, Bs, Vs, Sd,
               Nenhum, Invalido, Sem_Sinal, Atualiza
    );
endinterface

// File: rtl/mostrador7_leitor_seg7_padrao_dec.sv
// Combinational segment pattern to status code translation with invalid flag.
module seg7_padrao_dec
    import mostrador7_leitor_pkg::*;
(
    input  logic [6:0] padrao_i,
    output status_t    codigo_o,
    output logic       invalido_o
);

    always_comb begin
        codigo_o   = ST_NENHUM;
        invalido_o = 1'b0;
        case (padrao_i)
            PAT_NENHUM:  codigo_o = ST_NENHUM;
            PAT_CRITICO: codigo_o = ST_CRITICO;
            PAT_BAIXO:   codigo_o = ST_BAIXO;
            PAT_MEDIO:   codigo_o = ST_MEDIO;
            PAT_ALTO:    codigo_o = ST_ALTO;
            PAT_ERR:     codigo_o = ST_ERR;
            PAT_BS:      codigo_o = ST_BS;
            PAT_VS:      codigo_o = ST_VS;
            default:     invalido_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mostrador7_leitor.sv
// Reads the multiplexed seven-segment status digit, debounces the pattern and
// exposes it as registered one-hot indications plus a loss-of-signal flag.
//
// state   | meaning
// ESPERA  | no candidate pattern held
// FILTRA  | counting consecutive matching samples of the candidate
// ESTAVEL | candidate accepted, watching for a different pattern
module mostrador7_leitor
    import mostrador7_leitor_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    mostrador7_leitor_if.slave   bus
);

    localparam logic [7:0]  STABLE_LIM  = 8'(STABLE_CYCLES);
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    estado_t     estado_q, estado_d;
    logic [6:0]  cand_q, cand_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] tmo_q, tmo_d;

    logic        pend_q, pend_d;
    status_t     pend_codigo_q, pend_codigo_d;
    logic        pend_inv_q, pend_inv_d;

    status_t     codigo_q;
    logic        inv_q;
    logic        atualiza_q;
    logic        primeiro_q;

    status_t     dec_codigo;
    logic        dec_inv;
    logic        amostra;
    logic        sem_sinal;
    logic        perda;
    logic [8:0]  oh;

    seg7_padrao_dec u_dec (
        .padrao_i   (cand_q),
        .codigo_o   (dec_codigo),
        .invalido_o (dec_inv)
    );

    assign amostra   = ~bus.SEG_D1;
    assign sem_sinal = (tmo_q == TIMEOUT_LIM);
    assign perda     = (tmo_d == TIMEOUT_LIM) && !sem_sinal;

    always_comb begin
        tmo_d = tmo_q;
        if (amostra) begin
            tmo_d = '0;
        end else if (tmo_q != TIMEOUT_LIM) begin
            tmo_d = tmo_q + 16'd1;
        end
    end

    always_comb begin
        estado_d      = estado_q;
        cand_d        = cand_q;
        cnt_d         = cnt_q;
        pend_d        = 1'b0;
        pend_codigo_d = pend_codigo_q;
        pend_inv_d    = pend_inv_q;
        if (perda) begin
            estado_d = ESPERA;
            cnt_d    = '0;
        end else if (amostra) begin
            case (estado_q)
                ESPERA: begin
                    cand_d   = bus.SEGs;
                    cnt_d    = 8'd1;
                    estado_d = FILTRA;
                end
                FILTRA: begin
                    if (bus.SEGs == cand_q) begin
                        // Decoder sees cand_q, which equals this sample here
                        if (cnt_q + 8'd1 >= STABLE_LIM) begin
                            cnt_d         = STABLE_LIM;
                            estado_d      = ESTAVEL;
                            pend_d        = 1'b1;
                            pend_codigo_d = dec_codigo;
                            pend_inv_d    = dec_inv;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else begin
                        cand_d = bus.SEGs;
                        cnt_d  = 8'd1;
                    end
                end
                ESTAVEL: begin
                    if (bus.SEGs != cand_q) begin
                        cand_d   = bus.SEGs;
                        cnt_d    = 8'd1;
                        estado_d = FILTRA;
                    end
                end
                default: begin
                    estado_d = ESPERA;
                    cnt_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q      <= ESPERA;
            cand_q        <= '0;
            cnt_q         <= '0;
            tmo_q         <= '0;
            pend_q        <= 1'b0;
            pend_codigo_q <= ST_NENHUM;
            pend_inv_q    <= 1'b0;
        end else begin
            estado_q      <= estado_d;
            cand_q        <= cand_d;
            cnt_q         <= cnt_d;
            tmo_q         <= tmo_d;
            pend_q        <= pend_d;
            pend_codigo_q <= pend_codigo_d;
            pend_inv_q    <= pend_inv_d;
        end
    end

    // Outputs follow acceptance by one edge; Atualiza rides on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            codigo_q   <= ST_NENHUM;
            inv_q      <= 1'b0;
            atualiza_q <= 1'b0;
            primeiro_q <= 1'b1;
        end else if (pend_q) begin
            codigo_q   <= pend_codigo_q;
            inv_q      <= pend_inv_q;
            atualiza_q <= primeiro_q || ({pend_inv_q, pend_codigo_q} != {inv_q, codigo_q});
            primeiro_q <= 1'b0;
        end else begin
            atualiza_q <= 1'b0;
        end
    end

    assign oh = status_onehot(codigo_q, inv_q);

    assign bus.Nenhum     = oh[0];
    assign bus.Nv_Critico = oh[1];
    assign bus.Nv_Baixo   = oh[2];
    assign bus.Nv_Medio   = oh[3];
    assign bus.Nv_Alto    = oh[4];
    assign bus.Err        = oh[5];
    assign bus.Bs         = oh[6];
    assign bus.Vs         = oh[7];
    assign bus.Invalido   = oh[8];
    assign bus.Sd         = oh[6] | oh[7];
    assign bus.Sem_Sinal  = sem_sinal;
    assign bus.Atualiza   = atualiza_q;

endmodule

// File: tb/tb_mostrador7_leitor.sv
// Directed bench for the seven-segment status reader.
module tb_mostrador7_leitor;

    // Output vector: Nenhum Crit Baixo Medio Alto Err Bs Vs Inv Sd Sem Atu
    localparam logic [11:0] V_RESET    = 12'b1000_0000_0000;
    localparam logic [11:0] V_MEDIO_A  = 12'b0001_0000_0001;
    localparam logic [11:0] V_MEDIO    = 12'b0001_0000_0000;
    localparam logic [11:0] V_VS_A     = 12'b0000_0001_0101;
    localparam logic [11:0] V_VS       = 12'b0000_0001_0100;
    localparam logic [11:0] V_CRIT_A   = 12'b0100_0000_0001;
    localparam logic [11:0] V_CRIT     = 12'b0100_0000_0000;
    localparam logic [11:0] V_INV_A    = 12'b0000_0000_1001;
    localparam logic [11:0] V_BS       = 12'b0000_0010_0100;
    localparam logic [11:0] V_BS_SEM   = 12'b0000_0010_0110;
    localparam logic [11:0] V_ALTO_A   = 12'b0000_1000_0001;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    mostrador7_leitor_if bus ();

    mostrador7_leitor #(
        .STABLE_CYCLES  (4),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [11:0] outs();
        return {bus.Nenhum, bus.Nv_Critico, bus.Nv_Baixo, bus.Nv_Medio, bus.Nv_Alto,
                bus.Err, bus.Bs, bus.Vs, bus.Invalido, bus.Sd, bus.Sem_Sinal, bus.Atualiza};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus.SEGs   = 7'h00;
        bus.SEG_D1 = 1'b1;
        bus.SEG_D2 = 1'b1;
        bus.SEG_D3 = 1'b1;
        bus.SEG_D4 = 1'b1;
        repeat (3) step();
        checks++;
        if (outs() !== V_RESET) $display("FAIL reset_held: got %b expected %b", outs(), V_RESET);
        else passed++;
        rst = 1'b0;
        step();
        checks++;
        if (outs() !== V_RESET) $display("FAIL reset_release: got %b expected %b", outs(), V_RESET);
        else passed++;
    endtask

    task automatic test_aceita_medio();
        bus.SEGs   = 7'h37;
        bus.SEG_D1 = 1'b0;
        bus.SEG_D2 = 1'b0;
        repeat (4) step();
        checks++;
        if (outs() !== V_RESET) $display("FAIL medio_latency: got %b expected %b", outs(), V_RESET);
        else passed++;
        step();
        checks++;
        if (outs() !== V_MEDIO_A) $display("FAIL medio_accept: got %b expected %b", outs(), V_MEDIO_A);
        else passed++;
        step();
        checks++;
        if (outs() !== V_MEDIO) $display("FAIL medio_pulse_once: got %b expected %b", outs(), V_MEDIO);
        else passed++;
        bus.SEG_D2 = 1'b1;
    endtask

    task automatic test_varredura_vs();
        bus.SEGs = 7'h63;
        for (int i = 0; i < 7; i++) begin
            bus.SEG_D1 = i[0];
            step();
        end
        checks++;
        if (outs() !== V_MEDIO) $display("FAIL vs_hold_old: got %b expected %b", outs(), V_MEDIO);
        else passed++;
        bus.SEG_D1 = 1'b1;
        step();
        checks++;
        if (outs() !== V_VS_A) $display("FAIL vs_accept: got %b expected %b", outs(), V_VS_A);
        else passed++;
        bus.SEG_D1 = 1'b0;
        step();
        checks++;
        if (outs() !== V_VS) $display("FAIL vs_steady: got %b expected %b", outs(), V_VS);
        else passed++;
    endtask

    task automatic test_glitch_critico();
        bus.SEG_D1 = 1'b0;
        bus.SEGs   = 7'h27;
        repeat (5) step();
        checks++;
        if (outs() !== V_CRIT_A) $display("FAIL crit_accept: got %b expected %b", outs(), V_CRIT_A);
        else passed++;
        bus.SEGs = 7'h06;
        repeat (3) step();
        checks++;
        if (outs() !== V_CRIT) $display("FAIL crit_glitch_hold: got %b expected %b", outs(), V_CRIT);
        else passed++;
        bus.SEGs = 7'h27;
        for (int i = 0; i < 7; i++) begin
            step();
            checks++;
            if (outs() !== V_CRIT) $display("FAIL crit_no_update[%0d]: got %b expected %b", i, outs(), V_CRIT);
            else passed++;
        end
    endtask

    task automatic test_invalido();
        bus.SEGs = 7'h55;
        repeat (5) step();
        checks++;
        if (outs() !== V_INV_A) $display("FAIL invalid_accept: got %b expected %b", outs(), V_INV_A);
        else passed++;
    endtask

    task automatic test_tabela();
        logic [6:0]  pats [4] = '{7'h7F, 7'h77, 7'h06, 7'h03};
        logic [11:0] exps [4] = '{12'b1000_0000_0001, 12'b0010_0000_0001,
                                  12'b0000_0100_0001, 12'b0000_0010_0101};
        for (int i = 0; i < 4; i++) begin
            bus.SEGs = pats[i];
            repeat (5) step();
            checks++;
            if (outs() !== exps[i])
                $display("FAIL table[%0h]: got %b expected %b", pats[i], outs(), exps[i]);
            else passed++;
        end
        step();
        checks++;
        if (outs() !== V_BS) $display("FAIL bs_steady: got %b expected %b", outs(), V_BS);
        else passed++;
    endtask

    task automatic test_timeout();
        bus.SEG_D1 = 1'b1;
        bus.SEGs   = 7'h55;
        repeat (1023) step();
        checks++;
        if (outs() !== V_BS) $display("FAIL timeout_early: got %b expected %b", outs(), V_BS);
        else passed++;
        step();
        checks++;
        if (outs() !== V_BS_SEM) $display("FAIL timeout_assert: got %b expected %b", outs(), V_BS_SEM);
        else passed++;
        repeat (6) step();
        checks++;
        if (outs() !== V_BS_SEM) $display("FAIL timeout_saturate: got %b expected %b", outs(), V_BS_SEM);
        else passed++;
        bus.SEG_D1 = 1'b0;
        bus.SEGs   = 7'h03;
        step();
        checks++;
        if (outs() !== V_BS) $display("FAIL timeout_clear: got %b expected %b", outs(), V_BS);
        else passed++;
        repeat (4) step();
        checks++;
        if (outs() !== V_BS) $display("FAIL timeout_reaccept_same: got %b expected %b", outs(), V_BS);
        else passed++;
    endtask

    task automatic test_reset_meio();
        bus.SEGs = 7'h36;
        repeat (2) step();
        rst = 1'b1;
        #1;
        checks++;
        if (outs() !== V_RESET) $display("FAIL midreset_immediate: got %b expected %b", outs(), V_RESET);
        else passed++;
        step();
        rst = 1'b0;
        repeat (4) step();
        checks++;
        if (outs() !== V_RESET) $display("FAIL midreset_full_count: got %b expected %b", outs(), V_RESET);
        else passed++;
        step();
        checks++;
        if (outs() !== V_ALTO_A) $display("FAIL midreset_accept: got %b expected %b", outs(), V_ALTO_A);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_aceita_medio();
        test_varredura_vs();
        test_glitch_critico();
        test_invalido();
        test_tabela();
        test_timeout();
        test_reset_meio();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
